// File: rtl/sdram_cmd_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_sequencer_pkg
//  Description : Shared definitions for the SDRAM command sequencer:
//                SDRAM command pin encodings {CS_N,RAS_N,CAS_N,WE_N},
//                sequencer state encodings, SADDR field positions,
//                the delay-counter width and mode-register helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package sdram_cmd_sequencer_pkg;

   // Command pin encodings, ordered {CS_N, RAS_N, CAS_N, WE_N}
   localparam logic [3:0] C_CMD_INH = 4'b1111;  // deselect, reset value
   localparam logic [3:0] C_CMD_NOP = 4'b0111;
   localparam logic [3:0] C_CMD_ACT = 4'b0011;
   localparam logic [3:0] C_CMD_RD  = 4'b0101;
   localparam logic [3:0] C_CMD_WR  = 4'b0100;
   localparam logic [3:0] C_CMD_PRE = 4'b0010;
   localparam logic [3:0] C_CMD_REF = 4'b0001;
   localparam logic [3:0] C_CMD_MRS = 4'b0000;

   // Sequencer states; the encoding is also exported on the debug port
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE_W = 3'd1,
      ST_REF_W = 3'd2,
      ST_MRS_W = 3'd3,
      ST_ACT_W = 3'd4,
      ST_RD_W  = 3'd5,
      ST_WR_W  = 3'd6
   } state_t;

   // SADDR field positions
   localparam int C_COL_LSB  = 0;
   localparam int C_COL_MSB  = 7;
   localparam int C_ROW_LSB  = 8;
   localparam int C_ROW_MSB  = 18;
   localparam int C_BANK_LSB = 19;
   localparam int C_BANK_MSB = 20;

   // A10 selects auto-precharge on RD/WR and all-banks on PRE
   localparam logic [11:0] C_SA_A10 = 12'h400;

   // Delay counter width and largest loadable value
   localparam int C_CNT_W   = 5;
   localparam int C_CNT_MAX = (1 << C_CNT_W) - 1;

   // Mode register burst-length code (log2 of the burst length)
   function automatic logic [2:0] f_burst_code(input int bl);
      case (bl)
         1:       return 3'd0;
         2:       return 3'd1;
         4:       return 3'd2;
         default: return 3'd3;
      endcase
   endfunction

   // Mode word: burst write, CAS latency in A[6:4], sequential burst, BL code
   function automatic logic [11:0] f_mode_word(input int cas, input int bl);
      return {2'b00, 1'b0, 2'b00, 3'(cas), 1'b0, f_burst_code(bl)};
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_cmd_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_sequencer_if
//  Description : Bundle between the upstream decode/init stage, the command
//                sequencer and the SDRAM pins.
//                master : upstream side, drives decoded strobes and SADDR,
//                         receives acks, data-window strobes and pin values.
//                slave  : sequencer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface sdram_cmd_sequencer_if #(
   parameter int ASIZE = 21
);
   // upstream strobes / address
   logic             nop;
   logic             reada;
   logic             writea;
   logic             refresh;
   logic             precharge;
   logic             load_mode;
   logic             init_req;
   logic             ref_req;
   logic [ASIZE-1:0] saddr;
   // handshakes and data windows
   logic             ref_ack;
   logic             cm_ack;
   logic             oe;
   logic             rd_valid;
   // SDRAM pins
   logic [11:0]      sa;
   logic [1:0]       ba;
   logic             cs_n;
   logic             ras_n;
   logic             cas_n;
   logic             we_n;
   logic             cke;

   modport master (
      output nop, reada, writea, refresh, precharge, load_mode, init_req,
             ref_req, saddr,
      input  ref_ack, cm_ack, oe, rd_valid, sa, ba, cs_n, ras_n, cas_n,
             we_n, cke
   );

   modport slave (
      input  nop, reada, writea, refresh, precharge, load_mode, init_req,
             ref_req, saddr,
      output ref_ack, cm_ack, oe, rd_valid, sa, ba, cs_n, ras_n, cas_n,
             we_n, cke
   );
endinterface
`default_nettype wire

// File: rtl/sdram_cmd_sequencer_delay_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_sequencer_delay_cnt
//  Description : Loadable down-counter with zero flag. Loading N makes the
//                flag read zero on the (N+1)-th clock after the load edge.
//  Ports       : clk, rst (async, active high)
//                i_load      load strobe
//                i_load_val  value to load
//                o_zero      counter is zero
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_cmd_sequencer_delay_cnt
   import sdram_cmd_sequencer_pkg::*;
(
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               i_load,
   input  wire logic [C_CNT_W-1:0] i_load_val,
   output logic                    o_zero
);

   logic [C_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - C_CNT_W'(1);
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/sdram_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_cmd_sequencer
//  Description : SDRAM command sequencer. Turns decoded upstream strobes into
//                SDRAM commands while holding tRCD/tRP/tRFC/tMRD and the
//                CAS/burst/write-recovery windows. Reads and writes use
//                auto-precharge. All outputs are registered.
//  Ports       : clk       system clock
//                rst       asynchronous active-high reset
//                bus       sdram_cmd_sequencer_if.slave (strobes, SADDR,
//                          REF_ACK/CM_ACK, OE/RD_VALID, SDRAM pins)
//                state_dbg, ref_late  (only with SDRAM_SEQ_DEBUG_EN)
//  Config      : `define SDRAM_SEQ_DEBUG_EN adds STATE_DBG and a sticky
//                REF_LATE flag (REF_REQ pending for more than 64 cycles).
//  Revision    : 1.0  initial release
// ============================================================================
module sdram_cmd_sequencer
   import sdram_cmd_sequencer_pkg::*;
#(
   parameter int ASIZE     = 21,
   parameter int T_RCD     = 3,
   parameter int T_RP      = 3,
   parameter int T_RFC     = 7,
   parameter int T_MRD     = 2,
   parameter int T_WR      = 2,
   parameter int CAS_LAT   = 3,
   parameter int BURST_LEN = 8
)(
   input  wire logic             clk,
   input  wire logic             rst,
   sdram_cmd_sequencer_if.slave  bus
`ifdef SDRAM_SEQ_DEBUG_EN
   ,
   output logic [2:0]            state_dbg,
   output logic                  ref_late
`endif
);

   // Command-to-command spacing. A wait that returns to IDLE spends one
   // extra cycle in IDLE before the next command, hence the "-2"; the
   // ACT_W wait issues RD/WR itself on expiry, hence "-1".
   localparam int C_RD_TOT = CAS_LAT + BURST_LEN + T_RP;
   localparam int C_WR_TOT = BURST_LEN + T_WR + T_RP;

   localparam logic [C_CNT_W-1:0] C_LD_RCD = C_CNT_W'(T_RCD - 1);
   localparam logic [C_CNT_W-1:0] C_LD_RP  = C_CNT_W'(T_RP - 2);
   localparam logic [C_CNT_W-1:0] C_LD_RFC = C_CNT_W'(T_RFC - 2);
   localparam logic [C_CNT_W-1:0] C_LD_MRD = C_CNT_W'(T_MRD - 2);
   localparam logic [C_CNT_W-1:0] C_LD_RD  = C_CNT_W'(C_RD_TOT - 2);
   localparam logic [C_CNT_W-1:0] C_LD_WR  = C_CNT_W'(C_WR_TOT - 2);

   localparam logic [11:0]        C_MODE   = f_mode_word(CAS_LAT, BURST_LEN);
   localparam logic [3:0]         C_BL     = 4'(BURST_LEN);
   localparam logic [CAS_LAT-1:0] C_DLY_ONE = CAS_LAT'(1);

   generate
      if (ASIZE < 21 || T_RCD < 1 || T_RP < 2 || T_RFC < 2 || T_MRD < 2 ||
          T_WR < 0 || CAS_LAT < 1 || CAS_LAT > 7 ||
          !(BURST_LEN == 1 || BURST_LEN == 2 || BURST_LEN == 4 || BURST_LEN == 8) ||
          T_RCD - 1 > C_CNT_MAX || T_RP - 2 > C_CNT_MAX ||
          T_RFC - 2 > C_CNT_MAX || T_MRD - 2 > C_CNT_MAX ||
          C_RD_TOT - 2 > C_CNT_MAX || C_WR_TOT - 2 > C_CNT_MAX) begin : g_param_check
         $error("sdram_cmd_sequencer: parameters out of range for the 5-bit delay counter");
      end
   endgenerate

   // Registered state and outputs
   state_t       r_state;
   logic [3:0]   r_cmd;
   logic [11:0]  r_sa;
   logic [1:0]   r_ba;
   logic         r_cke;
   logic         r_cm_ack;
   logic         r_ref_ack;
   logic [7:0]   r_col;
   logic         r_is_rd;
   logic         r_armed;

   // Data windows
   logic [CAS_LAT-1:0] r_rd_dly;
   logic [3:0]         r_rd_left;
   logic               r_rd_valid;
   logic [3:0]         r_oe_left;
   logic               r_oe;

   // Decision outputs
   state_t               w_state_nxt;
   logic [3:0]           w_cmd;
   logic [11:0]          w_sa;
   logic [1:0]           w_ba;
   logic                 w_load;
   logic [C_CNT_W-1:0]   w_load_val;
   logic                 w_cm_ack;
   logic                 w_ref_ack;
   logic                 w_rd_issue;
   logic                 w_wr_issue;
   logic                 w_cnt_zero;
   logic                 w_rd_trig;

   sdram_cmd_sequencer_delay_cnt u_delay_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load),
      .i_load_val (w_load_val),
      .o_zero     (w_cnt_zero)
   );

   // Next command / state. SA and BA hold their last value across NOPs.
   always_comb begin
      w_state_nxt = r_state;
      w_cmd       = C_CMD_NOP;
      w_sa        = r_sa;
      w_ba        = r_ba;
      w_load      = 1'b0;
      w_load_val  = '0;
      w_cm_ack    = 1'b0;
      w_ref_ack   = 1'b0;
      w_rd_issue  = 1'b0;
      w_wr_issue  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!bus.init_req) begin
               if (bus.precharge) begin
                  w_cmd       = C_CMD_PRE;
                  w_sa        = C_SA_A10;
                  w_ba        = 2'b00;
                  w_load      = 1'b1;
                  w_load_val  = C_LD_RP;
                  w_state_nxt = ST_PRE_W;
               end else if (bus.load_mode) begin
                  w_cmd       = C_CMD_MRS;
                  w_sa        = C_MODE;
                  w_ba        = 2'b00;
                  w_load      = 1'b1;
                  w_load_val  = C_LD_MRD;
                  w_state_nxt = ST_MRS_W;
               end else if (bus.refresh || bus.ref_req) begin
                  // only the hidden-refresh request is acknowledged
                  w_cmd       = C_CMD_REF;
                  w_ref_ack   = !bus.refresh;
                  w_load      = 1'b1;
                  w_load_val  = C_LD_RFC;
                  w_state_nxt = ST_REF_W;
               end else if ((bus.reada || bus.writea) && r_armed) begin
                  w_cmd       = C_CMD_ACT;
                  w_ba        = bus.saddr[C_BANK_MSB:C_BANK_LSB];
                  w_sa        = {1'b0, bus.saddr[C_ROW_MSB:C_ROW_LSB]};
                  w_load      = 1'b1;
                  w_load_val  = C_LD_RCD;
                  w_state_nxt = ST_ACT_W;
               end
            end
         end
         ST_ACT_W: begin
            if (w_cnt_zero) begin
               w_cmd       = r_is_rd ? C_CMD_RD : C_CMD_WR;
               w_sa        = C_SA_A10 | {4'b0000, r_col};
               w_cm_ack    = 1'b1;
               w_load      = 1'b1;
               w_load_val  = r_is_rd ? C_LD_RD : C_LD_WR;
               w_state_nxt = r_is_rd ? ST_RD_W : ST_WR_W;
               w_rd_issue  = r_is_rd;
               w_wr_issue  = !r_is_rd;
            end
         end
         default: begin
            if (w_cnt_zero) begin
               w_state_nxt = ST_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_cmd     <= C_CMD_INH;
         r_sa      <= '0;
         r_ba      <= '0;
         r_cke     <= 1'b0;
         r_cm_ack  <= 1'b0;
         r_ref_ack <= 1'b0;
         r_col     <= '0;
         r_is_rd   <= 1'b0;
         r_armed   <= 1'b1;
      end else begin
         r_cke     <= 1'b1;
         r_state   <= w_state_nxt;
         r_cmd     <= w_cmd;
         r_sa      <= w_sa;
         r_ba      <= w_ba;
         r_cm_ack  <= w_cm_ack;
         r_ref_ack <= w_ref_ack;
         if (r_state == ST_IDLE && w_state_nxt == ST_ACT_W) begin
            r_col   <= bus.saddr[C_COL_MSB:C_COL_LSB];
            r_is_rd <= bus.reada;
         end
         // Upstream strobes are levels that lag the ack; a new access is
         // only accepted once both strobes have been seen low.
         if (w_cm_ack) begin
            r_armed <= 1'b0;
         end else if (bus.nop || !(bus.reada || bus.writea)) begin
            r_armed <= 1'b1;
         end
      end
   end

   // Read window opens CAS_LAT cycles after the RD command edge
   assign w_rd_trig = r_rd_dly[CAS_LAT-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_dly   <= '0;
         r_rd_left  <= '0;
         r_rd_valid <= 1'b0;
         r_oe_left  <= '0;
         r_oe       <= 1'b0;
      end else begin
         r_rd_dly <= (r_rd_dly << 1) | (w_rd_issue ? C_DLY_ONE : '0);

         if (w_rd_trig) begin
            r_rd_left  <= C_BL;
            r_rd_valid <= 1'b1;
         end else begin
            r_rd_valid <= (r_rd_left > 4'd1);
            if (r_rd_left != '0) begin
               r_rd_left <= r_rd_left - 4'd1;
            end
         end

         if (w_wr_issue) begin
            r_oe_left <= C_BL;
            r_oe      <= 1'b1;
         end else begin
            r_oe <= (r_oe_left > 4'd1);
            if (r_oe_left != '0) begin
               r_oe_left <= r_oe_left - 4'd1;
            end
         end
      end
   end

   assign bus.cs_n     = r_cmd[3];
   assign bus.ras_n    = r_cmd[2];
   assign bus.cas_n    = r_cmd[1];
   assign bus.we_n     = r_cmd[0];
   assign bus.sa       = r_sa;
   assign bus.ba       = r_ba;
   assign bus.cke      = r_cke;
   assign bus.cm_ack   = r_cm_ack;
   assign bus.ref_ack  = r_ref_ack;
   assign bus.oe       = r_oe;
   assign bus.rd_valid = r_rd_valid;

`ifdef SDRAM_SEQ_DEBUG_EN
   logic [6:0] r_ref_wait;
   logic       r_ref_late;

   // r_ref_wait holds the number of earlier cycles REF_REQ has been pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ref_wait <= '0;
         r_ref_late <= 1'b0;
      end else begin
         if (!bus.ref_req || w_ref_ack) begin
            r_ref_wait <= '0;
         end else if (r_ref_wait != 7'd127) begin
            r_ref_wait <= r_ref_wait + 7'd1;
         end
         if (bus.ref_req && !w_ref_ack && r_ref_wait >= 7'd64) begin
            r_ref_late <= 1'b1;
         end
      end
   end

   assign state_dbg = r_state;
   assign ref_late  = r_ref_late;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sdram_cmd_sequencer
//  Description : Self-checking bench for sdram_cmd_sequencer: reset/init
//                blocking, init command pulses, an IDLE-priority vector
//                table, and hand-written read, write, refresh-vs-read and
//                reset-during-read sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sdram_cmd_sequencer;
   import sdram_cmd_sequencer_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sdram_cmd_sequencer_if #(.ASIZE(21)) bus ();

`ifdef SDRAM_SEQ_DEBUG_EN
   logic [2:0] state_dbg;
   logic       ref_late;
`endif

   sdram_cmd_sequencer #(
      .ASIZE(21), .T_RCD(3), .T_RP(3), .T_RFC(7), .T_MRD(2),
      .T_WR(2), .CAS_LAT(3), .BURST_LEN(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus)
`ifdef SDRAM_SEQ_DEBUG_EN
      ,
      .state_dbg (state_dbg),
      .ref_late  (ref_late)
`endif
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   function automatic logic [3:0] pins();
      return {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n};
   endfunction

   // ---------------- event monitor (single process via tick) -------------
   int          cyc = 0;
   int          nonnop_cnt, act_cnt, act_first, act_last, rd_cnt, rd_first;
   int          wr_cnt, wr_first, ref_cnt, ref_first, rack_cnt, rack_first;
   int          cmack_cnt, cmack_first, rdv_cnt, rdv_first, rdv_last;
   int          oe_first, oe_fall;
   logic        oe_prev;
   logic [11:0] act_sa, rd_sa;
   logic [1:0]  act_ba;
   logic [3:0]  mon_c;

   task clear_mon();
      nonnop_cnt = 0; act_cnt = 0; act_first = -1; act_last = -1;
      rd_cnt = 0; rd_first = -1; wr_cnt = 0; wr_first = -1;
      ref_cnt = 0; ref_first = -1; rack_cnt = 0; rack_first = -1;
      cmack_cnt = 0; cmack_first = -1; rdv_cnt = 0; rdv_first = -1;
      rdv_last = -1; oe_first = -1; oe_fall = -1; oe_prev = 1'b0;
      act_sa = '0; rd_sa = '0; act_ba = '0;
   endtask

   task tick();
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mon_c = pins();
      if (mon_c != C_CMD_NOP) nonnop_cnt++;
      if (mon_c == C_CMD_ACT) begin
         if (act_cnt == 0) begin act_first = cyc; act_sa = bus.sa; act_ba = bus.ba; end
         act_last = cyc; act_cnt++;
      end
      if (mon_c == C_CMD_RD) begin
         if (rd_cnt == 0) begin rd_first = cyc; rd_sa = bus.sa; end
         rd_cnt++;
      end
      if (mon_c == C_CMD_WR) begin
         if (wr_cnt == 0) wr_first = cyc;
         wr_cnt++;
      end
      if (mon_c == C_CMD_REF) begin
         if (ref_cnt == 0) ref_first = cyc;
         ref_cnt++;
      end
      if (bus.ref_ack) begin
         if (rack_cnt == 0) rack_first = cyc;
         rack_cnt++;
      end
      if (bus.cm_ack) begin
         if (cmack_cnt == 0) cmack_first = cyc;
         cmack_cnt++;
      end
      if (bus.rd_valid) begin
         if (rdv_cnt == 0) rdv_first = cyc;
         rdv_last = cyc; rdv_cnt++;
      end
      if (bus.oe && oe_first < 0) oe_first = cyc;
      if (!bus.oe && oe_prev && oe_fall < 0) oe_fall = cyc;
      oe_prev = bus.oe;
   endtask

   task idle_inputs();
      bus.nop = 1'b1; bus.reada = 1'b0; bus.writea = 1'b0;
      bus.refresh = 1'b0; bus.precharge = 1'b0; bus.load_mode = 1'b0;
      bus.ref_req = 1'b0;
   endtask

   // ---------------- IDLE priority vector table ------------------------
   typedef struct {
      logic       init_req, precharge, load_mode, refresh, ref_req, reada, writea;
      logic [3:0] exp_cmd;
      logic       exp_ref_ack;
      logic       chk_sa;
      logic [11:0] exp_sa;
   } vec_t;

   vec_t vecs [8];
   int   t0;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //          init pre  mrs  ref  rreq rda  wra  cmd      rack chk  sa
      vecs[0] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,4'b0111,1'b0,1'b0,12'h000};
      vecs[1] = '{1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,4'b0010,1'b0,1'b1,12'h400};
      vecs[2] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,4'b0000,1'b0,1'b1,12'h033};
      vecs[3] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'b0001,1'b0,1'b0,12'h000};
      vecs[4] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,4'b0001,1'b1,1'b0,12'h000};
      vecs[5] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,4'b0011,1'b0,1'b1,12'h25C};
      vecs[6] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'b0011,1'b0,1'b1,12'h25C};
      vecs[7] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'b0111,1'b0,1'b0,12'h000};

      idle_inputs();
      bus.init_req = 1'b1;
      bus.saddr    = 21'h1A_5C3C;
      clear_mon();

      // ---- 1: reset values, CKE rise, INIT_REQ blocks everything ----
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_cke", int'(bus.cke), 0);
      chk("rst_pins", int'(pins()), 'hF);
      chk("rst_sa_ba", int'({bus.sa, bus.ba}), 0);
      chk("rst_acks", int'({bus.ref_ack, bus.cm_ack, bus.oe, bus.rd_valid}), 0);
      rst = 1'b0;
      tick();
      chk("cke_up", int'(bus.cke), 1);
      chk("idle_nop", int'(pins()), int'(C_CMD_NOP));
      bus.ref_req = 1'b1; bus.reada = 1'b1; bus.nop = 1'b0;
      clear_mon();
      repeat (100) tick();
      chk("init_block_cmds", nonnop_cnt, 0);
      chk("init_block_acks", rack_cnt + cmack_cnt, 0);
      idle_inputs();
      bus.init_req = 1'b0;
      repeat (3) tick();

      // ---- 2: init sequence PRE, 8x REF, MRS ----
      bus.precharge = 1'b1; tick(); bus.precharge = 1'b0;
      chk("init_pre_cmd", int'(pins()), int'(C_CMD_PRE));
      chk("init_pre_sa", int'(bus.sa), 'h400);
      repeat (5) tick();
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         bus.refresh = 1'b1; tick(); bus.refresh = 1'b0;
         repeat (19) tick();
      end
      chk("init_ref_count", ref_cnt, 8);
      chk("init_ref_no_ack", rack_cnt, 0);
      repeat (40) tick();
      bus.load_mode = 1'b1; tick(); bus.load_mode = 1'b0;
      chk("init_mrs_cmd", int'(pins()), int'(C_CMD_MRS));
      chk("init_mrs_sa", int'(bus.sa), 'h033);
      chk("init_mrs_ba", int'(bus.ba), 0);
      repeat (5) tick();

      // ---- IDLE priority table ----
      for (int i = 0; i < 8; i++) begin
         bus.init_req  = vecs[i].init_req;
         bus.precharge = vecs[i].precharge;
         bus.load_mode = vecs[i].load_mode;
         bus.refresh   = vecs[i].refresh;
         bus.ref_req   = vecs[i].ref_req;
         bus.reada     = vecs[i].reada;
         bus.writea    = vecs[i].writea;
         bus.nop       = !(vecs[i].reada || vecs[i].writea);
         tick();
         chk($sformatf("vec%0d_cmd", i), int'(pins()), int'(vecs[i].exp_cmd));
         chk($sformatf("vec%0d_ref_ack", i), int'(bus.ref_ack), int'(vecs[i].exp_ref_ack));
         if (vecs[i].chk_sa) chk($sformatf("vec%0d_sa", i), int'(bus.sa), int'(vecs[i].exp_sa));
         idle_inputs();
         bus.init_req = 1'b0;
         repeat (40) tick();
      end

      // ---- 3: held READA ----
      clear_mon();
      bus.reada = 1'b1; bus.nop = 1'b0;
      repeat (30) tick();
      idle_inputs();
      repeat (20) tick();
      chk("rd_act_count", act_cnt, 1);
      chk("rd_act_ba", int'(act_ba), 3);
      chk("rd_act_sa", int'(act_sa), 'h25C);
      chk("rd_trcd", rd_first - act_first, 3);
      chk("rd_sa", int'(rd_sa), 'h43C);
      chk("rd_cm_ack_count", cmack_cnt, 1);
      chk("rd_cm_ack_time", cmack_first - act_first, 3);
      chk("rd_valid_start", rdv_first - rd_first, 3);
      chk("rd_valid_end", rdv_last - rd_first, 10);
      chk("rd_valid_len", rdv_cnt, 8);

      // ---- 4: WRITEA, OE window and next-ACT spacing ----
      clear_mon();
      bus.writea = 1'b1; bus.nop = 1'b0;
      repeat (2) tick();
      idle_inputs();
      repeat (5) tick();
      bus.writea = 1'b1; bus.nop = 1'b0;
      repeat (30) tick();
      idle_inputs();
      repeat (30) tick();
      chk("wr_trcd", wr_first - act_first, 3);
      chk("wr_oe_start", oe_first - wr_first, 0);
      chk("wr_oe_len", oe_fall - oe_first, 8);
      chk("wr_act_count", act_cnt, 2);
      chk("wr_next_act", act_last - wr_first, 13);

      // ---- 5: REF_REQ and READA together ----
      clear_mon();
      t0 = cyc;
      bus.ref_req = 1'b1; bus.reada = 1'b1; bus.nop = 1'b0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (bus.ref_ack) bus.ref_req = 1'b0;
      end
      idle_inputs();
      repeat (25) tick();
      chk("rr_ref_first", ref_first - t0, 1);
      chk("rr_ref_ack_time", rack_first - t0, 1);
      chk("rr_ref_ack_count", rack_cnt, 1);
      chk("rr_act_after_trfc", act_first - ref_first, 7);
      chk("rr_act_count", act_cnt, 1);

      // ---- 6: reset in RD_W, then a fresh read ----
      clear_mon();
      bus.reada = 1'b1; bus.nop = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (rd_cnt > 0) break;
      end
      chk("rst6_rd_seen", rd_cnt, 1);
      repeat (4) tick();
      chk("rst6_rd_valid_before", int'(bus.rd_valid), 1);
      rst = 1'b1;
      #1;
      chk("rst6_rd_valid", int'(bus.rd_valid), 0);
      chk("rst6_pins", int'(pins()), 'hF);
      chk("rst6_cke", int'(bus.cke), 0);
      idle_inputs();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();
      chk("rst6_cke_up", int'(bus.cke), 1);
      clear_mon();
      bus.reada = 1'b1; bus.nop = 1'b0;
      repeat (20) tick();
      idle_inputs();
      repeat (20) tick();
      chk("rst6_act_count", act_cnt, 1);
      chk("rst6_act_sa", int'(act_sa), 'h25C);
      chk("rst6_trcd", rd_first - act_first, 3);
      chk("rst6_rd_valid_len", rdv_cnt, 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
